// File: rtl/inst_queue_nway.sv
// N-in/M-out in-order instruction queue on one shared circular buffer; fetch lanes are compacted and BPU-truncated on push.
// Optional perf counters under `INST_QUEUE_PERF_EN`; no combinational path from in_* to out_*, in_ready is registered.
module inst_queue_nway #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 32,
  parameter int PC_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [FETCH_WIDTH-1:0]          in_valid,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0] in_pc,
  input  logic [FETCH_WIDTH*32-1:0]       in_inst,
  input  logic [FETCH_WIDTH-1:0]          in_exc,
  input  logic [FETCH_WIDTH*7-1:0]        in_ecode,
  input  logic [FETCH_WIDTH-1:0]          in_is_branch,
  input  logic [FETCH_WIDTH-1:0]          in_pred_taken,
  input  logic [PC_WIDTH-1:0]             in_pred_target,
  output logic                            in_ready,
  output logic [ISSUE_WIDTH-1:0]          out_valid,
  output logic [ISSUE_WIDTH*PC_WIDTH-1:0] out_pc,
  output logic [ISSUE_WIDTH*32-1:0]       out_inst,
  output logic [ISSUE_WIDTH-1:0]          out_exc,
  output logic [ISSUE_WIDTH*7-1:0]        out_ecode,
  output logic [ISSUE_WIDTH-1:0]          out_is_branch,
  output logic [ISSUE_WIDTH-1:0]          out_pred_taken,
  output logic [ISSUE_WIDTH*PC_WIDTH-1:0] out_pred_target,
  input  logic [ISSUE_WIDTH-1:0]          out_accept,
  output logic [$clog2(DEPTH):0]          count,
  output logic [31:0]                     perf_full_cycles,
  output logic [31:0]                     perf_empty_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         inst;
    logic                exc;
    logic [6:0]          ecode;
    logic                is_branch;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           lane_ent [FETCH_WIDTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [FETCH_WIDTH-1:0] keep;
  logic [CW-1:0]    push_n;
  logic [CW-1:0]    pop_n;
  logic [CW-1:0]    count_next;
  logic             push_alive;
  logic             pop_run;

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lane_ent[k].pc          = in_pc[k*PC_WIDTH +: PC_WIDTH];
      lane_ent[k].inst        = in_inst[k*32 +: 32];
      lane_ent[k].exc         = in_exc[k];
      lane_ent[k].ecode       = in_ecode[k*7 +: 7];
      lane_ent[k].is_branch   = in_is_branch[k];
      lane_ent[k].pred_taken  = in_pred_taken[k];
      lane_ent[k].pred_target = in_pred_target;
    end
  end

  // Kept lanes form a prefix: stop at the first invalid lane or just after a predicted-taken branch.
  always_comb begin
    keep       = '0;
    push_n     = '0;
    push_alive = 1'b1;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (push_alive && in_valid[k]) begin
        keep[k] = 1'b1;
        push_n  = push_n + CW'(1);
        if (in_is_branch[k] && in_pred_taken[k]) push_alive = 1'b0;
      end else begin
        push_alive = 1'b0;
      end
    end
    if (!in_ready || flush) begin
      keep   = '0;
      push_n = '0;
    end
  end

  always_comb begin
    pop_n   = '0;
    pop_run = 1'b1;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (pop_run && out_valid[i] && out_accept[i]) pop_n = pop_n + CW'(1);
      else pop_run = 1'b0;
    end
  end

  assign count_next = flush ? '0 : (count + push_n - pop_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      head     <= flush ? '0 : head + pop_n[PW-1:0];
      tail     <= flush ? '0 : tail + push_n[PW-1:0];
      count    <= count_next;
      in_ready <= (CW'(DEPTH) - count_next) >= CW'(FETCH_WIDTH);
    end
  end

  // Entry storage needs no reset: every read is masked by out_valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (keep[k]) mem[tail + PW'(k)] <= lane_ent[k];
    end
  end

  always_comb begin
    out_valid       = '0;
    out_pc          = '0;
    out_inst        = '0;
    out_exc         = '0;
    out_ecode       = '0;
    out_is_branch   = '0;
    out_pred_taken  = '0;
    out_pred_target = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      out_valid[i] = count > CW'(i);
      if (out_valid[i]) begin
        out_pc[i*PC_WIDTH +: PC_WIDTH]          = mem[head + PW'(i)].pc;
        out_inst[i*32 +: 32]                    = mem[head + PW'(i)].inst;
        out_exc[i]                              = mem[head + PW'(i)].exc;
        out_ecode[i*7 +: 7]                     = mem[head + PW'(i)].ecode;
        out_is_branch[i]                        = mem[head + PW'(i)].is_branch;
        out_pred_taken[i]                       = mem[head + PW'(i)].pred_taken;
        out_pred_target[i*PC_WIDTH +: PC_WIDTH] = mem[head + PW'(i)].pred_target;
      end
    end
  end

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] full_q;
  logic [31:0] empty_q;

  // Saturating; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= '0;
      empty_q <= '0;
    end else begin
      if (!in_ready && in_valid[0] && (full_q != 32'hFFFF_FFFF)) full_q <= full_q + 32'd1;
      if ((count == '0) && !flush && (empty_q != 32'hFFFF_FFFF)) empty_q <= empty_q + 32'd1;
    end
  end

  assign perf_full_cycles  = full_q;
  assign perf_empty_cycles = empty_q;
`else
  assign perf_full_cycles  = 32'd0;
  assign perf_empty_cycles = 32'd0;
`endif

endmodule
